pwm_capture: RTL and testbench

- Receive-side counterpart of the team's fixed-period PWM generator: 100 MHz clock, 2,000,000-cycle (20 ms) frame, 2-bit duty code.
- Measures the high time and period of an incoming PWM line and decodes them back to the 2-bit duty code.
- Flags a stuck-high line (100 % duty) and loss of signal.
- Sits on the input side of a board-level link. Feeds a status or register block, one measurement per frame.

---
 rtl/pwm_capture.sv | 172 +++++++++++++++++
 tb/tb_pwm_capture.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rising-to-rising period of an
// incoming PWM line, decodes the 2-bit duty code, and flags a stuck-high
// or lost line. The optional glitch filter is enabled by defining
// PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W      = 22,
    parameter int TIMEOUT    = 2_100_000,
    parameter int TH0        = 750_000,
    parameter int TH1        = 1_250_000,
    parameter int TH2        = 1_750_000,
    parameter int FILTER_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [1:0]       duty,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             stuck_hi,
    output logic             lost
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    typedef struct packed {
        logic [1:0]       duty;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] period;
    } meas_t;

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] T0     = CNT_W'(TH0);
    localparam logic [CNT_W-1:0] T1     = CNT_W'(TH1);
    localparam logic [CNT_W-1:0] T2     = CNT_W'(TH2);

    logic lvl_cur, lvl_prev;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    logic [1:0]    sync_pipe;
    logic          flt_lvl, flt_prev;
    logic [FW-1:0] flt_cnt;

    // two-flop synchronizer for the asynchronous line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[0], pwm_in};
    end

    // accept a new level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_lvl  <= 1'b0;
            flt_prev <= 1'b0;
            flt_cnt  <= '0;
        end else begin
            flt_prev <= flt_lvl;
            if (sync_pipe[1] == flt_lvl) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                flt_lvl <= sync_pipe[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign lvl_cur  = flt_lvl;
    assign lvl_prev = flt_prev;
`else
    logic [2:0] sync_pipe;

    // two-flop synchronizer plus the edge-detector history flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[1:0], pwm_in};
    end

    assign lvl_cur  = sync_pipe[1];
    assign lvl_prev = sync_pipe[2];
`endif

    logic rise, fall;
    assign rise = lvl_cur & ~lvl_prev;
    assign fall = ~lvl_cur & lvl_prev;

    function automatic logic [1:0] decode(input logic [CNT_W-1:0] h);
        if (h < T0)      return 2'b00;
        else if (h < T1) return 2'b01;
        else if (h < T2) return 2'b10;
        else             return 2'b11;
    endfunction

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, high_q, high_d;
    meas_t            res_q, res_d;
    logic             valid_d, stuck_d, lost_d;

    // state, counter, latched high time and published results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            high_q   <= '0;
            res_q    <= '0;
            valid    <= 1'b0;
            stuck_hi <= 1'b0;
            lost     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            high_q   <= high_d;
            res_q    <= res_d;
            valid    <= valid_d;
            stuck_hi <= stuck_d;
            lost     <= lost_d;
        end
    end

    // next state: edges win over a timeout landing in the same cycle
    always_comb begin
        state_d = state;
        cnt_d   = (cnt == TMO) ? cnt : cnt + ONE;
        if (rise || fall) cnt_d = '0;
        high_d  = high_q;
        res_d   = res_q;
        valid_d = 1'b0;
        stuck_d = stuck_hi;
        lost_d  = lost;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    lost_d  = 1'b0;
                end else if (cnt >= TMO_M1) begin
                    lost_d = 1'b1;
                end
            end
            HIGH: begin
                if (fall) begin
                    high_d  = cnt + ONE;
                    stuck_d = 1'b0;
                    state_d = LOW;
                end else if (cnt == TMO_M1) begin
                    stuck_d = 1'b1;
                    valid_d = 1'b1;
                    res_d   = '{duty: 2'b11, high: TMO, period: TMO};
                    cnt_d   = '0;
                end
            end
            LOW: begin
                if (rise) begin
                    valid_d = 1'b1;
                    res_d   = '{duty: decode(high_q), high: high_q,
                                period: high_q + cnt + ONE};
                    state_d = HIGH;
                end else if (cnt == TMO_M1) begin
                    lost_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign duty       = res_q.duty;
    assign high_cnt   = res_q.high;
    assign period_cnt = res_q.period;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture with scaled-down timing (frame 2000, timeout 2100).
module tb_pwm_capture;
    localparam int CW   = 13;
    localparam int TMO  = 2100;
    localparam int FLEN = 4;

    logic          clk, rst_n, pwm_in;
    logic [1:0]    duty;
    logic [CW-1:0] high_cnt, period_cnt;
    logic          valid, stuck_hi, lost;

    pwm_capture #(
        .CNT_W(CW), .TIMEOUT(TMO), .TH0(750), .TH1(1250), .TH2(1750),
        .FILTER_LEN(FLEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .duty(duty),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .valid(valid),
        .stuck_hi(stuck_hi), .lost(lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int n_valid = 0, last_duty = 0, last_high = 0, last_period = 0;

    // reference model: timestamps of the last rise/restart and the fall
    int   m, t_ref, t_fall, t_clr, hq;
    int   e_duty, e_high, e_period;
    logic e_valid, e_stuck, e_lost;
    logic [15:0] hist, lh;

    function automatic int dec(input int h);
        if (h < 750)       return 0;
        else if (h < 1250) return 1;
        else if (h < 1750) return 2;
        else               return 3;
    endfunction

    task automatic model_reset();
        m = 0; t_ref = -1; t_fall = -1; t_clr = 0; hq = 0;
        hist = '0; lh = '0;
        e_duty = 0; e_high = 0; e_period = 0;
        e_valid = 0; e_stuck = 0; e_lost = 0;
    endtask

    initial begin
        logic cur, prv, rs, fl, lv;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                m++;
                e_valid = 0;
                hist = {hist[14:0], pwm_in};
                lv = lh[0];
                if (hist[FLEN-1:0] == {FLEN{~lv}}) lv = ~lv;
                lh = {lh[14:0], lv};
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
                cur = lh[3]; prv = lh[4];
`else
                cur = hist[2]; prv = hist[3];
`endif
                rs = cur & ~prv;
                fl = ~cur & prv;
                if (t_ref < 0) begin
                    if (rs) begin
                        t_ref = m; e_lost = 0;
                    end else begin
                        if (m - t_clr >= TMO) e_lost = 1;
                        if (fl) t_clr = m;
                    end
                end else if (t_fall < 0) begin
                    if (fl) begin
                        hq = m - t_ref; t_fall = m; e_stuck = 0;
                    end else if (m - t_ref == TMO) begin
                        e_valid = 1; e_duty = 3; e_high = TMO; e_period = TMO;
                        e_stuck = 1; t_ref = m;
                    end
                end else begin
                    if (rs) begin
                        e_valid = 1; e_high = hq; e_period = m - t_ref;
                        e_duty = dec(hq); t_ref = m; t_fall = -1;
                    end else if (m - t_fall == TMO) begin
                        e_lost = 1; t_ref = -1; t_fall = -1; t_clr = m - TMO;
                    end
                end
            end
        end
    end

    // per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                n_chk++;
                if (valid !== e_valid || stuck_hi !== e_stuck || lost !== e_lost ||
                    duty !== 2'(e_duty) || high_cnt !== CW'(e_high) ||
                    period_cnt !== CW'(e_period)) begin
                    n_err++;
                    $display("FAIL cycle %0d: got v=%b s=%b l=%b d=%0d h=%0d p=%0d want v=%b s=%b l=%b d=%0d h=%0d p=%0d",
                             m, valid, stuck_hi, lost, duty, high_cnt, period_cnt,
                             e_valid, e_stuck, e_lost, e_duty, e_high, e_period);
                end
                if (valid === 1'b1) begin
                    n_valid++;
                    last_duty = int'(duty); last_high = int'(high_cnt);
                    last_period = int'(period_cnt);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic chk_last(input string nm, input int d, input int h, input int p);
        chk({nm, "_duty"}, last_duty, d);
        chk({nm, "_high"}, last_high, h);
        chk({nm, "_period"}, last_period, p);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_duty"}, int'(duty), 0);
        chk({nm, "_high"}, int'(high_cnt), 0);
        chk({nm, "_period"}, int'(period_cnt), 0);
        chk({nm, "_valid"}, int'(valid), 0);
        chk({nm, "_stuck"}, int'(stuck_hi), 0);
        chk({nm, "_lost"}, int'(lost), 0);
    endtask

    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input int h, input int p);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int hs[6], ds[6], nv0;
        hs = '{500, 500, 1000, 1000, 1500, 1500};
        ds = '{0, 0, 1, 1, 2, 2};
        rst_n = 1'b0; pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        hold(1'b0, 50);

        // duty 00, 01, 10, two frames each; each frame is reported at the next rise
        for (int i = 0; i < 6; i++) begin
            frame(hs[i], 2000);
            if (i == 0) chk("first_frame_no_valid", n_valid, 0);
            else        chk_last($sformatf("frame%0d", i - 1), ds[i-1], hs[i-1], 2000);
        end

        // stuck high: the rise reports the last frame, then three timeouts
        nv0 = n_valid;
        hold(1'b1, 3 * TMO + 50);
        chk("stuck_valids", n_valid - nv0, 4);
        chk("stuck_flag", int'(stuck_hi), 1);
        chk_last("stuck", 3, TMO, TMO);
        hold(1'b0, 50);
        chk("stuck_clear", int'(stuck_hi), 0);

        // lost: long low, no valid, old results held
        hold(1'b0, 2150);
        chk("lost_flag", int'(lost), 1);
        chk("lost_no_valid", n_valid - nv0, 4);
        chk("lost_duty_held", int'(duty), 3);
        frame(1000, 2000);
        chk("lost_clear", int'(lost), 0);
        chk("lost_first_frame", n_valid - nv0, 4);
        frame(1000, 2000);
        chk_last("recover", 1, 1000, 2000);

        // edges landing exactly on the timeout cycle
        frame(TMO, 2 * TMO);
        frame(1000, 2000);
        chk_last("edge_at_timeout", 3, TMO, 2 * TMO);

        // reset in the middle of a high pulse
        hold(1'b1, 700);
        rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        pwm_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        hold(1'b0, 20);
        nv0 = n_valid;
        frame(1000, 2000);
        chk("post_reset_no_valid", n_valid - nv0, 0);
        frame(1000, 2000);
        chk("post_reset_valid", n_valid - nv0, 1);
        chk_last("post_reset", 1, 1000, 2000);

        // 2-cycle glitch inside the low phase
        hold(1'b1, 1000); hold(1'b0, 400); hold(1'b1, 2); hold(1'b0, 598);
        frame(1000, 2000);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        chk_last("glitch_filtered", 1, 1000, 2000);
`else
        chk_last("glitch_raw", 0, 2, 600);
`endif

        // random pulse trains, checked cycle by cycle against the model
        for (int i = 0; i < 10; i++) begin
            hold(1'b1, $urandom_range(1, 2300));
            hold(1'b0, $urandom_range(1, 2300));
        end
        hold(1'b0, 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
